// File: rtl/powerup_pkg.sv
// powerup_pkg: shared slot state type and counter widths for the power-up scheduler
// Contents:
//   slot_state_t  per-slot lifecycle IDLE -> EMERGE -> ACTIVE -> COLLECT
//   EMERGE_W      width of the emerge frame counter
//   LIFE_W        width of the life frame counter (POWERUP_TIMEOUT_EN builds)
package powerup_pkg;
    typedef enum logic [1:0] {IDLE, EMERGE, ACTIVE, COLLECT} slot_state_t;
    localparam int EMERGE_W = 8;
    localparam int LIFE_W   = 10;
endpackage

// File: rtl/powerup_slot.sv
// powerup_slot: one on-screen power-up slot, emerge -> active -> despawn lifecycle
// Ports:
//   Clk, Reset     clock, synchronous active-high reset
//   frame_tick     one-Clk pulse per video frame, paces emerge and life counters
//   start          claim this IDLE slot (from the scheduler arbiter)
//   src_in         requester index recorded on start
//   collision      player touching the sprite (acted on only in ACTIVE)
//   offscreen      sprite left the playfield (acted on only in ACTIVE)
//   idle           slot free for a new grant
//   slot_on        registered: sprite visible (EMERGE or ACTIVE)
//   slot_emerge    registered: sprite rising, no physics
//   collected      registered one-Clk pulse when the player takes the power-up
//   src            requester that owns / last owned the slot
// Build option: POWERUP_TIMEOUT_EN adds a life counter that despawns an ACTIVE
// slot after LIFE_FRAMES frame ticks without a collected pulse.
module powerup_slot
    import powerup_pkg::*;
#(
    parameter int SRC_W         = 2,
    parameter int EMERGE_FRAMES = 16,
    parameter int LIFE_FRAMES   = 600
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             start,
    input  logic [SRC_W-1:0] src_in,
    input  logic             collision,
    input  logic             offscreen,
    output logic             idle,
    output logic             slot_on,
    output logic             slot_emerge,
    output logic             collected,
    output logic [SRC_W-1:0] src
);
    if (EMERGE_FRAMES < 1 || EMERGE_FRAMES > 255 || LIFE_FRAMES < 1 || LIFE_FRAMES > 1024) begin : g_bad_cfg
        $error("powerup_slot: EMERGE_FRAMES or LIFE_FRAMES out of range");
    end

    slot_state_t         state;
    logic [EMERGE_W-1:0] emerge_cnt;
    logic                emerge_done;
    logic                timeout;

    assign idle        = state == IDLE;
    assign emerge_done = state == EMERGE && frame_tick && emerge_cnt == '0;

`ifdef POWERUP_TIMEOUT_EN
    logic [LIFE_W-1:0] life_cnt;

    assign timeout = frame_tick && life_cnt == '0;

    always_ff @(posedge Clk) begin
        if (Reset)
            life_cnt <= '0;
        else if (emerge_done)
            life_cnt <= LIFE_W'(LIFE_FRAMES - 1);
        else if (state == ACTIVE && frame_tick && life_cnt != '0)
            life_cnt <= life_cnt - 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            emerge_cnt  <= '0;
            slot_on     <= 1'b0;
            slot_emerge <= 1'b0;
            collected   <= 1'b0;
            src         <= '0;
        end else begin
            collected <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= EMERGE;
                    emerge_cnt  <= EMERGE_W'(EMERGE_FRAMES - 1);
                    slot_on     <= 1'b1;
                    slot_emerge <= 1'b1;
                    src         <= src_in;
                end
                EMERGE: if (emerge_done) begin
                    state       <= ACTIVE;
                    slot_emerge <= 1'b0;
                end else if (frame_tick) begin
                    emerge_cnt  <= emerge_cnt - 1'b1;
                end
                // collision outranks both offscreen and timeout
                ACTIVE: if (collision) begin
                    state     <= COLLECT;
                    slot_on   <= 1'b0;
                    collected <= 1'b1;
                end else if (offscreen || timeout) begin
                    state     <= IDLE;
                    slot_on   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/powerup_scheduler.sv
// powerup_scheduler: round-robin sharing of power-up slots between question-block requesters
// Ports:
//   Clk, Reset     clock, synchronous active-high reset
//   frame_tick     one-Clk pulse per video frame
//   req            per-requester level, held until granted
//   grant          registered one-hot one-Clk grant pulse
//   collision      per-slot player contact
//   offscreen      per-slot sprite left the playfield
//   slot_on        per-slot visible (EMERGE or ACTIVE)
//   slot_emerge    per-slot rising out of the block
//   slot_src       owner requester of slot i at [i*SRC_W +: SRC_W]
//   collected      per-slot one-Clk collected pulse
// Build option: POWERUP_TIMEOUT_EN enables the per-slot life timeout.
module powerup_scheduler
    import powerup_pkg::*;
#(
    parameter  int NUM_SLOTS     = 2,
    parameter  int NUM_REQ       = 4,
    parameter  int EMERGE_FRAMES = 16,
    parameter  int LIFE_FRAMES   = 600,
    localparam int SRC_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_tick,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    input  logic [NUM_SLOTS-1:0]       collision,
    input  logic [NUM_SLOTS-1:0]       offscreen,
    output logic [NUM_SLOTS-1:0]       slot_on,
    output logic [NUM_SLOTS-1:0]       slot_emerge,
    output logic [NUM_SLOTS*SRC_W-1:0] slot_src,
    output logic [NUM_SLOTS-1:0]       collected
);
    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_cfg
        $error("powerup_scheduler: NUM_SLOTS or NUM_REQ out of range");
    end

    logic [NUM_SLOTS-1:0] idle;
    logic [NUM_SLOTS-1:0] start;
    logic [SRC_W-1:0]     ptr;
    logic [SRC_W-1:0]     pick;
    logic [SRC_W-1:0]     idx;
    logic                 found;

    // first requester at or after ptr; a requester still seeing its grant is skipped
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx] && !grant[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // isolate the lowest IDLE slot; idle is registered state, so a slot freed
    // on this edge only becomes grantable next cycle
    assign start = found ? idle & (~idle + NUM_SLOTS'(1)) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            grant <= '0;
            ptr   <= '0;
        end else begin
            grant <= '0;
            if (found && |idle) begin
                grant <= NUM_REQ'(1) << pick;
                ptr   <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        powerup_slot #(
            .SRC_W        (SRC_W),
            .EMERGE_FRAMES(EMERGE_FRAMES),
            .LIFE_FRAMES  (LIFE_FRAMES)
        ) u_slot (
            .Clk        (Clk),
            .Reset      (Reset),
            .frame_tick (frame_tick),
            .start      (start[i]),
            .src_in     (pick),
            .collision  (collision[i]),
            .offscreen  (offscreen[i]),
            .idle       (idle[i]),
            .slot_on    (slot_on[i]),
            .slot_emerge(slot_emerge[i]),
            .collected  (collected[i]),
            .src        (slot_src[i*SRC_W +: SRC_W])
        );
    end
endmodule

// File: tb/tb_powerup_scheduler.sv
// tb_powerup_scheduler: randomized scoreboard bench for powerup_scheduler
module tb_powerup_scheduler;
    localparam int NS = 2;
    localparam int NR = 4;
    localparam int EF = 16;
    localparam int LF = 600;
    localparam int SW = 2;
    localparam int P_FREE = 0;
    localparam int P_RISE = 1;
    localparam int P_LIVE = 2;
    localparam int P_GONE = 3;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           frame_tick = 1'b0;
    logic [NR-1:0]  req = '0;
    logic [NR-1:0]  grant;
    logic [NS-1:0]  collision = '0;
    logic [NS-1:0]  offscreen = '0;
    logic [NS-1:0]  slot_on;
    logic [NS-1:0]  slot_emerge;
    logic [NS*SW-1:0] slot_src;
    logic [NS-1:0]  collected;

    typedef struct {int r; int s;} grant_t;
    grant_t        gq[$];
    logic [NS-1:0] cq[$];

    int            phase[NS];
    int            ticks[NS];
    int            m_ptr = 0;
    logic [NR-1:0] m_grant = '0;
    logic          m_rst = 1'b0;
    logic [NR-1:0] late = '0;
    int            checks = 0;
    int            errors = 0;

    powerup_scheduler #(
        .NUM_SLOTS(NS), .NUM_REQ(NR), .EMERGE_FRAMES(EF), .LIFE_FRAMES(LF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .req(req), .grant(grant),
        .collision(collision), .offscreen(offscreen), .slot_on(slot_on),
        .slot_emerge(slot_emerge), .slot_src(slot_src), .collected(collected)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: what one clock edge does to the slot pool, from the behavioural rules
    task automatic model_edge();
        int s;
        int r;
        int c;
        logic [NS-1:0] col;
        m_rst = Reset;
        if (Reset) begin
            for (int i = 0; i < NS; i++) begin
                phase[i] = P_FREE;
                ticks[i] = 0;
            end
            m_ptr = 0;
            m_grant = '0;
            return;
        end
        s = -1;
        for (int i = NS - 1; i >= 0; i--) if (phase[i] == P_FREE) s = i;
        r = -1;
        if (s >= 0)
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (r < 0 && req[c] && !m_grant[c]) r = c;
            end
        col = '0;
        for (int i = 0; i < NS; i++) begin
            if (phase[i] == P_RISE) begin
                if (frame_tick) begin
                    ticks[i]++;
                    if (ticks[i] == EF) begin
                        phase[i] = P_LIVE;
                        ticks[i] = 0;
                    end
                end
            end else if (phase[i] == P_LIVE) begin
                if (collision[i]) begin
                    phase[i] = P_GONE;
                    col[i] = 1'b1;
                end else if (offscreen[i]) begin
                    phase[i] = P_FREE;
                end
`ifdef POWERUP_TIMEOUT_EN
                else if (frame_tick) begin
                    ticks[i]++;
                    if (ticks[i] == LF) phase[i] = P_FREE;
                end
`endif
            end else if (phase[i] == P_GONE) begin
                phase[i] = P_FREE;
            end
        end
        m_grant = '0;
        if (r >= 0) begin
            phase[s] = P_RISE;
            ticks[s] = 0;
            m_grant[r] = 1'b1;
            m_ptr = (r + 1) % NR;
            gq.push_back('{r, s});
        end
        if (col != '0) cq.push_back(col);
    endtask

    // monitor: pops expectations whenever the DUT presents a grant or collected pulse
    initial begin
        grant_t        e;
        logic [NS-1:0] ec;
        logic [NS-1:0] on_e;
        logic [NS-1:0] em_e;
        forever begin
            @(posedge Clk);
            #1;
            if (grant != '0) begin
                if (gq.size() == 0) check("grant_unexpected", 32'(grant), 0);
                else begin
                    e = gq.pop_front();
                    check("grant", 32'(grant), 32'(1) << e.r);
                    check("slot_src", 32'(slot_src[e.s*SW +: SW]), e.r);
                end
            end else if (gq.size() != 0) begin
                e = gq.pop_front();
                check("grant_missing", 32'(grant), 32'(1) << e.r);
            end
            if (collected != '0) begin
                if (cq.size() == 0) check("collected_unexpected", 32'(collected), 0);
                else begin
                    ec = cq.pop_front();
                    check("collected", 32'(collected), 32'(ec));
                end
            end else if (cq.size() != 0) begin
                ec = cq.pop_front();
                check("collected_missing", 32'(collected), 32'(ec));
            end
            for (int i = 0; i < NS; i++) begin
                on_e[i] = phase[i] == P_RISE || phase[i] == P_LIVE;
                em_e[i] = phase[i] == P_RISE;
            end
            check("slot_on", 32'(slot_on), 32'(on_e));
            check("slot_emerge", 32'(slot_emerge), 32'(em_e));
            if (m_rst) check("src_reset", 32'(slot_src), 0);
        end
    end

    // stimulus: random requesters, frame ticks and sprite events, with reset bursts
    // and a quiet stretch where slots stay occupied (pending reqs, timeouts)
    initial begin
        bit quiet;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge Clk);
            Reset = (cyc < 3) || (cyc >= 1000 && cyc < 1002) || (cyc >= 4500 && cyc < 4502);
            quiet = cyc >= 1500 && cyc < 4000;
            frame_tick = ($urandom % 3) == 0;
            for (int r = 0; r < NR; r++) begin
                if (late[r]) begin
                    req[r] = 1'b0;
                    late[r] = 1'b0;
                end else if (grant[r]) begin
                    if ($urandom % 2) req[r] = 1'b0;
                    else late[r] = 1'b1;
                end else if (!req[r] && ($urandom % 8) == 0) begin
                    req[r] = 1'b1;
                end
            end
            for (int i = 0; i < NS; i++) begin
                collision[i] = !quiet && ($urandom % 12) == 0;
                offscreen[i] = !quiet && ($urandom % 12) == 0;
            end
            @(posedge Clk);
            model_edge();
        end
        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
